pc_sequencer: RTL and testbench

- Parametrised program counter for the mips_16 fetch path.
- Supports increment, absolute jump, signed relative branch, call/return through a hardware return-address stack, single-step back, and optional end-of-memory wrap.
- Advances only on a qualifying `tick` from the rate divider, so one fast `clk` replaces the divided-clock scheme.
- Reports stack state and sticky error flags to the debug/status logic.

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_ret_stack.sv | 71 +++++++
 rtl/pc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the pc_sequencer fetch-path program counter.
// Operation encodings and default sizing live here so the sequencer,
// its return stack and any surrounding logic agree on them.
package pc_pkg;

  // Operation codes presented on `op`; 3'b111 is reserved and acts as hold.
  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD   = 3'b000;
  localparam op_t OP_INC    = 3'b001;
  localparam op_t OP_JUMP   = 3'b010;
  localparam op_t OP_BRANCH = 3'b011;
  localparam op_t OP_CALL   = 3'b100;
  localparam op_t OP_RET    = 3'b101;
  localparam op_t OP_BACK   = 3'b110;

  // Default sizing: 1K-word program memory, four-deep return stack.
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_SP_W        = 3;

  // Index width needed to address `depth` stack slots (at least one bit).
  function automatic int stack_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : pc_pkg

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_sequencer.
// Holds STACK_DEPTH addresses; push while full and pop while empty are
// silently dropped so the parent can flag overflow/underflow itself.
// `clr` empties the stack synchronously; Clear_n empties it asynchronously.
// Slot contents are never reset: only the occupancy count matters.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int SP_W        = DEF_SP_W
) (
  input  logic              clk,
  input  logic              Clear_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = stack_idx_w(STACK_DEPTH);

  logic [SP_W-1:0]   r_sp;
  logic [ADDR_W-1:0] r_mem [2**IDX_W];

  logic              w_do_push;
  logic              w_do_pop;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign full  = (r_sp == SP_W'(STACK_DEPTH));
  assign empty = (r_sp == '0);
  assign sp    = r_sp;

  // A push and a pop never arrive together from the sequencer; push wins if
  // they ever do, and a synchronous clear cancels both.
  assign w_do_push = push && !full && !clr;
  assign w_do_pop  = pop && !empty && !clr && !push;

  // Next free slot is at index sp; the top entry sits one below it.
  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));

  // Top of stack is read straight from the slot array.
  assign top = r_mem[w_rd_idx];

  // Occupancy count: async clear, sync clear, then push/pop.
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_sp <= '0;
    end else if (clr) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Slot storage: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule : pc_ret_stack

// File: rtl/pc_sequencer.sv
// Program counter for the mips_16 fetch path.
// Advances only on cycles where `tick` is high, supporting increment,
// absolute jump, relative branch, call/return via pc_ret_stack, single-step
// back and optional end-of-memory wrap. sclr restarts everything
// synchronously and outranks tick.
// Optional feature macro: PC_BREAKPOINT_EN adds bp_addr/bp_en/bp_resume
// inputs and a `halted` output that freezes the PC after it lands on
// bp_addr until a resume pulse.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int SP_W        = DEF_SP_W
) (
  input  logic              clk,
  input  logic              Clear_n,
  input  logic              tick,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] Jaddr,
  input  logic [ADDR_W-1:0] Boff,
  input  logic              Enloop,
  input  logic              sclr,
  output logic [ADDR_W-1:0] Caddr,
  output logic [SP_W-1:0]   sp,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              ovf,
  output logic              unf,
  output logic              at_end
`ifdef PC_BREAKPOINT_EN
  ,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  input  logic              bp_resume,
  output logic              halted
`endif
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_ret_addr;
  logic [ADDR_W-1:0] w_top;
  logic [SP_W-1:0]   w_sp;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic              w_ops_frozen;

  // Return address of a CALL is the word after the call site, wrapping.
  assign w_ret_addr = r_addr + ADDR_W'(1);

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .SP_W        (SP_W)
  ) u_ret_stack (
    .clk     (clk),
    .Clear_n (Clear_n),
    .clr     (sclr),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_ret_addr),
    .top     (w_top),
    .sp      (w_sp),
    .full    (w_full),
    .empty   (w_empty)
  );

`ifdef PC_BREAKPOINT_EN
  logic r_halted;
  logic r_resumed;

  assign w_ops_frozen = r_halted;
  assign halted       = r_halted;

  // Breakpoint control: halt after landing on bp_addr, release on resume.
  // The first tick after a resume is exempt from matching so execution can
  // step off the breakpoint even when the PC still equals bp_addr.
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_halted  <= 1'b0;
      r_resumed <= 1'b0;
    end else if (sclr) begin
      r_halted  <= 1'b0;
      r_resumed <= 1'b0;
    end else if (r_halted) begin
      if (bp_resume) begin
        r_halted  <= 1'b0;
        r_resumed <= 1'b1;
      end
    end else if (tick) begin
      r_resumed <= 1'b0;
      if (bp_en && !r_resumed && (w_next_addr == bp_addr)) begin
        r_halted <= 1'b1;
      end
    end
  end
`else
  assign w_ops_frozen = 1'b0;
`endif

  // Decode the operation into the next PC and stack/flag requests.
  always_comb begin
    w_next_addr = r_addr;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    if (tick && !sclr && !w_ops_frozen) begin
      case (op)
        OP_HOLD: begin
          w_next_addr = r_addr;
        end
        OP_INC: begin
          if (r_addr != '1) begin
            w_next_addr = r_addr + ADDR_W'(1);
          end else if (Enloop) begin
            w_next_addr = '0;
          end
        end
        OP_JUMP: begin
          w_next_addr = Jaddr;
        end
        OP_BRANCH: begin
          // Two's-complement offset: plain modular add covers both signs.
          w_next_addr = r_addr + Boff;
        end
        OP_CALL: begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_next_addr = Jaddr;
          end else begin
            w_set_ovf = 1'b1;
          end
        end
        OP_RET: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_next_addr = w_top;
          end else begin
            w_set_unf = 1'b1;
          end
        end
        OP_BACK: begin
          if (r_addr != '0) begin
            w_next_addr = r_addr - ADDR_W'(1);
          end
        end
        default: begin
          w_next_addr = r_addr;
        end
      endcase
    end
  end

  // PC and sticky error flags; sclr restarts, otherwise take the decode.
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_addr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (sclr) begin
      r_addr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_addr <= w_next_addr;
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign Caddr     = r_addr;
  assign sp        = w_sp;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign at_end    = (r_addr == '1) && !Enloop;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table, a few
// hand-written multi-cycle sequences, then randomized operation against a
// queue-based reference model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int SPW   = 3;
  localparam int MAXA  = (1 << AW) - 1;
  localparam int NV    = 34;
  localparam int NRND  = 2000;

  logic           clk;
  logic           Clear_n;
  logic           tick;
  logic [2:0]     op;
  logic [AW-1:0]  Jaddr;
  logic [AW-1:0]  Boff;
  logic           Enloop;
  logic           sclr;
  logic [AW-1:0]  Caddr;
  logic [SPW-1:0] sp;
  logic           stk_full;
  logic           stk_empty;
  logic           ovf;
  logic           unf;
  logic           at_end;
`ifdef PC_BREAKPOINT_EN
  logic [AW-1:0]  bp_addr;
  logic           bp_en;
  logic           bp_resume;
  logic           halted;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .SP_W(SPW)) dut (
    .clk       (clk),
    .Clear_n   (Clear_n),
    .tick      (tick),
    .op        (op),
    .Jaddr     (Jaddr),
    .Boff      (Boff),
    .Enloop    (Enloop),
    .sclr      (sclr),
    .Caddr     (Caddr),
    .sp        (sp),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .ovf       (ovf),
    .unf       (unf),
    .at_end    (at_end)
`ifdef PC_BREAKPOINT_EN
    ,
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .bp_resume (bp_resume),
    .halted    (halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // Apply one cycle of inputs, let one posedge pass, sample 1ns later.
  task automatic drive(input logic t, input logic [2:0] o, input logic [AW-1:0] ja,
                       input logic [AW-1:0] bo, input logic en, input logic sc);
    tick   = t;
    op     = o;
    Jaddr  = ja;
    Boff   = bo;
    Enloop = en;
    sclr   = sc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          tick;
    logic [2:0]    op;
    logic [AW-1:0] jaddr;
    logic [AW-1:0] boff;
    logic          enloop;
    logic          sclr;
    int            exp_pc;
    int            exp_sp;
    bit            exp_ovf;
    bit            exp_unf;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic t, input logic [2:0] o, input int ja, input int bo,
                              input logic en, input logic sc, input int pc, input int spv,
                              input bit ov, input bit un);
    vec_t v;
    v.tick = t; v.op = o; v.jaddr = AW'(ja); v.boff = AW'(bo);
    v.enloop = en; v.sclr = sc;
    v.exp_pc = pc; v.exp_sp = spv; v.exp_ovf = ov; v.exp_unf = un;
    return v;
  endfunction

  // Reference model: PC as an integer, return stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  function automatic void model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_step(input logic t, input logic [2:0] o, input int ja,
                                     input int bo, input logic en, input logic sc);
    if (sc) begin
      model_reset();
    end else if (t) begin
      case (o)
        OP_INC:    if (m_pc == MAXA) begin if (en) m_pc = 0; end else m_pc = m_pc + 1;
        OP_JUMP:   m_pc = ja;
        OP_BRANCH: m_pc = (m_pc + bo) % (MAXA + 1);
        OP_CALL:   if (m_stk.size() == DEPTH) m_ovf = 1;
                   else begin m_stk.push_back((m_pc + 1) % (MAXA + 1)); m_pc = ja; end
        OP_RET:    if (m_stk.size() == 0) m_unf = 1; else m_pc = m_stk.pop_back();
        OP_BACK:   if (m_pc > 0) m_pc = m_pc - 1;
        default:   ;
      endcase
    end
  endfunction

  initial begin
    // Directed table: each row is one cycle from the previous row's state.
    vecs[0]  = mk(1, OP_INC,    0,     0, 0, 0,    1, 0, 0, 0);
    vecs[1]  = mk(0, OP_INC,    0,     0, 0, 0,    1, 0, 0, 0);
    vecs[2]  = mk(1, OP_INC,    0,     0, 0, 0,    2, 0, 0, 0);
    vecs[3]  = mk(0, OP_JUMP,   500,   0, 0, 0,    2, 0, 0, 0);
    vecs[4]  = mk(1, OP_INC,    0,     0, 0, 0,    3, 0, 0, 0);
    vecs[5]  = mk(1, OP_INC,    0,     0, 0, 0,    4, 0, 0, 0);
    vecs[6]  = mk(0, OP_INC,    0,     0, 0, 0,    4, 0, 0, 0);
    vecs[7]  = mk(1, OP_INC,    0,     0, 0, 0,    5, 0, 0, 0);
    vecs[8]  = mk(1, OP_JUMP,   1023,  0, 0, 0, 1023, 0, 0, 0);
    vecs[9]  = mk(1, OP_INC,    0,     0, 0, 0, 1023, 0, 0, 0);
    vecs[10] = mk(1, OP_INC,    0,     0, 1, 0,    0, 0, 0, 0);
    vecs[11] = mk(1, OP_JUMP,   100,   0, 0, 0,  100, 0, 0, 0);
    vecs[12] = mk(1, OP_BRANCH, 0, 'h3F6, 0, 0,   90, 0, 0, 0);
    vecs[13] = mk(1, OP_JUMP,   5,     0, 0, 0,    5, 0, 0, 0);
    vecs[14] = mk(1, OP_BRANCH, 0, 'h3F6, 1, 0, 1019, 0, 0, 0);
    vecs[15] = mk(1, OP_JUMP,   20,    0, 0, 0,   20, 0, 0, 0);
    vecs[16] = mk(1, OP_CALL,   300,   0, 0, 0,  300, 1, 0, 0);
    vecs[17] = mk(1, OP_CALL,   400,   0, 0, 0,  400, 2, 0, 0);
    vecs[18] = mk(1, OP_CALL,   500,   0, 0, 0,  500, 3, 0, 0);
    vecs[19] = mk(1, OP_CALL,   600,   0, 0, 0,  600, 4, 0, 0);
    vecs[20] = mk(1, OP_CALL,   700,   0, 0, 0,  600, 4, 1, 0);
    vecs[21] = mk(1, OP_RET,    0,     0, 0, 0,  501, 3, 1, 0);
    vecs[22] = mk(1, OP_RET,    0,     0, 0, 0,  401, 2, 1, 0);
    vecs[23] = mk(1, OP_RET,    0,     0, 0, 0,  301, 1, 1, 0);
    vecs[24] = mk(1, OP_RET,    0,     0, 0, 0,   21, 0, 1, 0);
    vecs[25] = mk(1, OP_RET,    0,     0, 0, 0,   21, 0, 1, 1);
    vecs[26] = mk(1, OP_JUMP,   0,     0, 0, 0,    0, 0, 1, 1);
    vecs[27] = mk(1, OP_BACK,   0,     0, 0, 0,    0, 0, 1, 1);
    vecs[28] = mk(1, OP_JUMP,   7,     0, 0, 0,    7, 0, 1, 1);
    vecs[29] = mk(1, OP_BACK,   0,     0, 0, 0,    6, 0, 1, 1);
    vecs[30] = mk(1, 3'b111,    900,   0, 0, 0,    6, 0, 1, 1);
    vecs[31] = mk(1, OP_HOLD,   900,   0, 0, 0,    6, 0, 1, 1);
    vecs[32] = mk(1, OP_CALL,   50,    0, 0, 0,   50, 1, 1, 1);
    vecs[33] = mk(0, OP_JUMP,   800,   0, 0, 1,    0, 0, 0, 0);

    // Asynchronous reset, checked before any clock edge.
    Clear_n = 1'b0;
    tick = 0; op = OP_HOLD; Jaddr = '0; Boff = '0; Enloop = 0; sclr = 0;
`ifdef PC_BREAKPOINT_EN
    bp_addr = '0; bp_en = 0; bp_resume = 0;
`endif
    #3;
    chk("rst_caddr", 32'(Caddr), 0);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(stk_empty), 1);
    chk("rst_full", 32'(stk_full), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
`ifdef PC_BREAKPOINT_EN
    chk("rst_halted", 32'(halted), 0);
`endif
    $display("reset: Caddr=%0d sp=%0d", Caddr, sp);
    @(negedge clk);
    Clear_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_caddr", 32'(Caddr), 0);

    // Table-driven directed vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].tick, vecs[i].op, vecs[i].jaddr, vecs[i].boff, vecs[i].enloop, vecs[i].sclr);
      chk($sformatf("vec%0d_caddr", i), 32'(Caddr), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_sp", i), 32'(sp), 32'(vecs[i].exp_sp));
      chk($sformatf("vec%0d_full", i), 32'(stk_full), 32'(vecs[i].exp_sp == DEPTH));
      chk($sformatf("vec%0d_empty", i), 32'(stk_empty), 32'(vecs[i].exp_sp == 0));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i), 32'(unf), 32'(vecs[i].exp_unf));
      chk($sformatf("vec%0d_at_end", i), 32'(at_end),
          32'((vecs[i].exp_pc == MAXA) && !vecs[i].enloop));
      $display("vec %0d: tick=%0d op=%0d -> Caddr=%0d sp=%0d ovf=%0d unf=%0d",
               i, vecs[i].tick, vecs[i].op, Caddr, sp, ovf, unf);
    end

    // Clear_n dropped while a CALL is pending: state clears with no clock.
    drive(1, OP_JUMP, 10'd20, '0, 0, 0);
    drive(1, OP_CALL, 10'd300, '0, 0, 0);
    chk("midcall_pre_caddr", 32'(Caddr), 300);
    chk("midcall_pre_sp", 32'(sp), 1);
    tick = 1; op = OP_CALL; Jaddr = 10'd400;
    #2;
    Clear_n = 1'b0;
    #1;
    chk("midcall_caddr", 32'(Caddr), 0);
    chk("midcall_sp", 32'(sp), 0);
    chk("midcall_empty", 32'(stk_empty), 1);
    $display("mid-call reset: Caddr=%0d sp=%0d", Caddr, sp);
    @(negedge clk);
    Clear_n = 1'b1;
    op = OP_HOLD;
    @(posedge clk);
    #1;
    chk("midcall_after_caddr", 32'(Caddr), 0);
    chk("midcall_after_sp", 32'(sp), 0);

`ifdef PC_BREAKPOINT_EN
    // Breakpoint: halt on reaching 4, ignore ops, resume, step to 5.
    bp_addr = 10'd4; bp_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1, OP_INC, '0, '0, 0, 0);
      chk($sformatf("bp_inc%0d_caddr", k), 32'(Caddr), 32'(k));
      chk($sformatf("bp_inc%0d_halted", k), 32'(halted), 32'(k == 4));
    end
    drive(1, OP_INC, '0, '0, 0, 0);
    chk("bp_frozen_caddr", 32'(Caddr), 4);
    chk("bp_frozen_halted", 32'(halted), 1);
    bp_resume = 1'b1;
    drive(0, OP_HOLD, '0, '0, 0, 0);
    bp_resume = 1'b0;
    chk("bp_resume_halted", 32'(halted), 0);
    drive(1, OP_INC, '0, '0, 0, 0);
    chk("bp_step_caddr", 32'(Caddr), 5);
    chk("bp_step_halted", 32'(halted), 0);
    $display("breakpoint: Caddr=%0d halted=%0d", Caddr, halted);
    bp_en = 1'b0;
    drive(0, OP_HOLD, '0, '0, 0, 1);
`else
    drive(0, OP_HOLD, '0, '0, 0, 1);
`endif

    // Randomized operation against the reference model.
    model_reset();
    for (int n = 0; n < NRND; n++) begin
      logic          r_t;
      logic [2:0]    r_o;
      logic [AW-1:0] r_ja;
      logic [AW-1:0] r_bo;
      logic          r_en;
      logic          r_sc;
      r_t  = ($urandom_range(3) != 0);
      r_o  = 3'($urandom_range(7));
      r_ja = ($urandom_range(3) == 0) ? AW'(MAXA - $urandom_range(3)) : AW'($urandom);
      r_bo = AW'($urandom);
      r_en = 1'($urandom_range(1));
      r_sc = ($urandom_range(49) == 0);
      drive(r_t, r_o, r_ja, r_bo, r_en, r_sc);
      model_step(r_t, r_o, int'(r_ja), int'(r_bo), r_en, r_sc);
      chk("rnd_caddr", 32'(Caddr), 32'(m_pc));
      chk("rnd_sp", 32'(sp), 32'(m_stk.size()));
      chk("rnd_full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
      chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
      chk("rnd_unf", 32'(unf), 32'(m_unf));
      chk("rnd_at_end", 32'(at_end), 32'((m_pc == MAXA) && !r_en));
    end
    $display("random: %0d cycles applied", NRND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_sequencer
